// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: locks the FIFO write port to one producer per burst,
// honouring full (stall) and almost-full (no new burst) flags.
module fifo_wr_arbiter #(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned DATA_W    = 128,
    parameter  int unsigned MAX_BURST = 16,
    localparam int unsigned GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    input  logic                        fifo_alm_full,
    output logic                        o_wren,
    output logic [DATA_W-1:0]           o_wdata,
    output logic [GW-1:0]               o_grant_id,
    output logic                        o_busy,
    output logic [CW-1:0]               o_beat_cnt,
    output logic [31:0]                 o_total_cnt,
    output logic                        o_err
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [31:0]     total_q, total_d;
    logic            err_q, err_d;

    logic            accept_c;
    logic            win_found_c;
    logic [GW-1:0]   winner_c;
    logic [GW-1:0]   idx_c;

    // First valid requester searching upward from last_grant+1, wrapping
    always_comb begin
        win_found_c = 1'b0;
        winner_c    = '0;
        idx_c       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx_c = GW'((32'(last_q) + i) % NUM_REQ);
            if (!win_found_c && req_valid[idx_c]) begin
                win_found_c = 1'b1;
                winner_c    = idx_c;
            end
        end
    end

    assign accept_c = (state_q == BURST) && req_valid[grant_q] && !fifo_full;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        total_d = total_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (win_found_c && !fifo_alm_full) begin
                    grant_d = winner_c;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept_c) begin
                    beat_d  = beat_q + CW'(1);
                    total_d = total_q + 32'd1;
                    if (req_last[grant_q]) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end else if (beat_q == CW'(MAX_BURST - 1)) begin
                        // Runaway burst: cut it off and flag it
                        state_d = IDLE;
                        last_d  = grant_q;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            beat_q  <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    // Write side is combinational so the FIFO takes the beat on the accepting edge
    always_comb begin
        req_ready = '0;
        o_wdata   = '0;
        if (state_q == BURST) begin
            o_wdata = req_data[32'(grant_q)*DATA_W +: DATA_W];
            if (!reset) begin
                req_ready[grant_q] = !fifo_full;
            end
        end
    end

    assign o_wren      = accept_c && !reset;
    assign o_grant_id  = grant_q;
    assign o_busy      = (state_q == BURST);
    assign o_beat_cnt  = beat_q;
    assign o_total_cnt = total_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 128;
    localparam int unsigned MB = 16;
    localparam int unsigned GW = 2;
    localparam int unsigned CW = 5;

    typedef logic [DW:0] beat_t;   // {last, data}

    typedef struct {
        logic         rst;
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         full;
        logic         alm;
        logic         e_wren;
        logic [N-1:0] e_ready;
        logic         e_busy;
        logic [GW-1:0] e_gid;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_last, req_ready;
    logic [N*DW-1:0]   req_data;
    logic              fifo_full, fifo_alm_full;
    logic              o_wren;
    logic [DW-1:0]     o_wdata;
    logic [GW-1:0]     o_grant_id;
    logic              o_busy;
    logic [CW-1:0]     o_beat_cnt;
    logic [31:0]       o_total_cnt;
    logic              o_err;

    int n_chk = 0;
    int n_err = 0;

    beat_t         pq [N][$];
    logic [N-1:0]  gap;
    logic [DW-1:0] wlog_d [$];
    int            wlog_id [$];

    // Reference model: who owns the port, who went last, beats and totals
    bit          m_busy, m_err;
    int          m_g, m_gid, m_last, m_beats;
    int unsigned m_total;

    vec_t tbl [15];

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_alm_full(fifo_alm_full),
        .o_wren(o_wren), .o_wdata(o_wdata), .o_grant_id(o_grant_id),
        .o_busy(o_busy), .o_beat_cnt(o_beat_cnt), .o_total_cnt(o_total_cnt),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_wren) begin
            wlog_d.push_back(o_wdata);
            wlog_id.push_back(int'(o_grant_id));
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic push(input int k, input int len, input bit with_last, input logic [DW-1:0] base);
        for (int j = 0; j < len; j++)
            pq[k].push_back({with_last && (j == len - 1), base + DW'(j)});
    endtask

    task automatic clear_log();
        wlog_d.delete();
        wlog_id.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        fifo_full = 1'b0; fifo_alm_full = 1'b0; gap = '0;
        for (int k = 0; k < N; k++) pq[k].delete();
        @(posedge clk); #1;
        m_busy = 0; m_err = 0; m_g = 0; m_gid = 0; m_last = N - 1; m_beats = 0; m_total = 0;
        chk("rst_busy",  DW'(o_busy), '0);
        chk("rst_gid",   DW'(o_grant_id), '0);
        chk("rst_beats", DW'(o_beat_cnt), '0);
        chk("rst_total", DW'(o_total_cnt), '0);
        chk("rst_err",   DW'(o_err), '0);
        chk("rst_wren",  DW'(o_wren), '0);
        chk("rst_ready", DW'(req_ready), '0);
        chk("rst_wdata", o_wdata, '0);
        reset = 1'b0;
        clear_log();
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (pq[k].size() > 0 && !gap[k]) begin
                req_valid[k] = 1'b1;
                req_last[k]  = pq[k][0][DW];
                req_data[k*DW +: DW] = pq[k][0][DW-1:0];
            end else begin
                req_valid[k] = 1'b0;
                req_last[k]  = 1'b0;
                req_data[k*DW +: DW] = '0;
            end
        end
    endtask

    // One clock: check the write side before the edge, the registered state after it
    task automatic step();
        logic [N-1:0]  e_ready;
        logic          e_wren;
        logic [DW-1:0] e_wdata;
        drive_inputs();
        #1;
        e_ready = '0; e_wren = 1'b0; e_wdata = '0;
        if (!reset && m_busy) begin
            e_ready[m_g] = !fifo_full;
            e_wren = req_valid[m_g] && !fifo_full;
            e_wdata = req_data[m_g*DW +: DW];
        end
        chk("ready", DW'(req_ready), DW'(e_ready));
        chk("wren",  DW'(o_wren), DW'(e_wren));
        if (e_wren) chk("wdata", o_wdata, e_wdata);
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_err = 0; m_g = 0; m_gid = 0; m_last = N - 1; m_beats = 0; m_total = 0;
        end else if (!m_busy) begin
            if (req_valid != '0 && !fifo_alm_full) begin
                for (int k = 1; k <= N; k++) begin
                    if (!m_busy && req_valid[(m_last + k) % N]) begin
                        m_g = (m_last + k) % N;
                        m_busy = 1;
                    end
                end
                m_gid = m_g;
                m_beats = 0;
            end
        end else if (e_wren) begin
            m_beats++;
            m_total++;
            void'(pq[m_g].pop_front());
            if (req_last[m_g] || m_beats == MB) begin
                m_busy = 0;
                m_last = m_g;
                if (!req_last[m_g]) m_err = 1;
            end
        end
        #1;
        chk("gid",   DW'(o_grant_id), DW'(m_gid));
        chk("busy",  DW'(o_busy), DW'(m_busy));
        chk("beats", DW'(o_beat_cnt), DW'(m_beats));
        chk("total", DW'(o_total_cnt), DW'(m_total));
        chk("err",   DW'(o_err), DW'(m_err));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int cnt;
        logic [DW-1:0] base;

        //          rst  valid    last     full alm  wren ready    busy gid
        tbl[0]  = '{0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 1, 2'd2};
        tbl[1]  = '{0, 4'b0100, 4'b0000, 0, 0, 1, 4'b0100, 1, 2'd2};
        tbl[2]  = '{0, 4'b0100, 4'b0000, 0, 0, 1, 4'b0100, 1, 2'd2};
        tbl[3]  = '{0, 4'b0100, 4'b0100, 0, 0, 1, 4'b0100, 0, 2'd2};
        tbl[4]  = '{0, 4'b1010, 4'b0000, 0, 1, 0, 4'b0000, 0, 2'd2};
        tbl[5]  = '{0, 4'b1010, 4'b0000, 0, 1, 0, 4'b0000, 0, 2'd2};
        tbl[6]  = '{0, 4'b1010, 4'b0000, 0, 0, 0, 4'b0000, 1, 2'd3};
        tbl[7]  = '{0, 4'b1010, 4'b0000, 0, 1, 1, 4'b1000, 1, 2'd3};
        tbl[8]  = '{0, 4'b1010, 4'b1000, 1, 0, 0, 4'b0000, 1, 2'd3};
        tbl[9]  = '{0, 4'b1010, 4'b1000, 0, 0, 1, 4'b1000, 0, 2'd3};
        tbl[10] = '{0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0000, 1, 2'd1};
        tbl[11] = '{0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0010, 1, 2'd1};
        tbl[12] = '{0, 4'b0010, 4'b0010, 0, 0, 1, 4'b0010, 0, 2'd1};
        tbl[13] = '{1, 4'b0001, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0};
        tbl[14] = '{0, 4'b1001, 4'b0000, 0, 0, 0, 4'b0000, 1, 2'd0};

        apply_reset();
        for (int i = 0; i < 15; i++) begin
            reset = tbl[i].rst; req_valid = tbl[i].valid; req_last = tbl[i].last;
            fifo_full = tbl[i].full; fifo_alm_full = tbl[i].alm; req_data = '0;
            #1;
            chk("tv_wren",  DW'(o_wren), DW'(tbl[i].e_wren));
            chk("tv_ready", DW'(req_ready), DW'(tbl[i].e_ready));
            @(posedge clk); #1;
            chk("tv_busy", DW'(o_busy), DW'(tbl[i].e_busy));
            chk("tv_gid",  DW'(o_grant_id), DW'(tbl[i].e_gid));
        end

        // Single 3-beat burst from requester 2
        apply_reset();
        base = {{31{4'hA}}, 4'h1};
        push(2, 3, 1, base);
        run(6);
        chk("single_n", DW'(wlog_d.size()), DW'(3));
        for (int i = 0; i < wlog_d.size() && i < 3; i++)
            chk("single_data", wlog_d[i], base + DW'(i));
        chk("single_total", DW'(o_total_cnt), DW'(3));
        chk("single_busy",  DW'(o_busy), '0);

        // Round-robin with every requester offering 1-beat bursts
        apply_reset();
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 10; j++) push(k, 1, 1, DW'(k * 100 + j));
        run(16);
        chk("rr_n", DW'(wlog_id.size()), DW'(8));
        for (int i = 0; i < wlog_id.size() && i < 8; i++)
            chk("rr_order", DW'(wlog_id[i]), DW'(i % N));
        for (int k = 0; k < N; k++) begin
            cnt = 0;
            foreach (wlog_id[i]) if (wlog_id[i] == k) cnt++;
            chk("rr_share", DW'(cnt), DW'(2));
        end

        // FIFO full for 5 cycles starting on beat 2 of 4
        apply_reset();
        base = 128'h5555_0000_0000_0000_0000_0000_0000_0010;
        push(1, 4, 1, base);
        run(2);
        fifo_full = 1'b1;
        run(5);
        fifo_full = 1'b0;
        run(5);
        chk("bp_n", DW'(wlog_d.size()), DW'(4));
        for (int i = 0; i < wlog_d.size() && i < 4; i++)
            chk("bp_data", wlog_d[i], base + DW'(i));

        // Almost-full gates new bursts but not an active one
        apply_reset();
        push(1, 3, 1, DW'(32'h100));
        push(3, 3, 1, DW'(32'h300));
        fifo_alm_full = 1'b1;
        run(4);
        chk("alm_idle_n", DW'(wlog_d.size()), '0);
        fifo_alm_full = 1'b0;
        run(1);
        fifo_alm_full = 1'b1;
        run(4);
        chk("alm_burst_n", DW'(wlog_d.size()), DW'(3));
        chk("alm_burst_id", DW'(o_grant_id), DW'(1));
        fifo_alm_full = 1'b0;
        run(5);

        // Forced termination after MAX_BURST beats without last
        apply_reset();
        push(0, 20, 0, DW'(32'h1000));
        push(1, 1, 1, DW'(32'h2000));
        run(30);
        chk("force_n", DW'(wlog_id.size()), DW'(21));
        cnt = 0;
        for (int i = 0; i < wlog_id.size() && i < 16; i++) if (wlog_id[i] == 0) cnt++;
        chk("force_run0", DW'(cnt), DW'(16));
        if (wlog_id.size() > 16) chk("force_next", DW'(wlog_id[16]), DW'(1));
        chk("force_err", DW'(o_err), DW'(1));

        // Reset landing on beat 2 of 5
        apply_reset();
        push(2, 5, 1, DW'(32'h7000));
        run(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_n", DW'(wlog_d.size()), DW'(1));
        push(0, 1, 1, DW'(32'h8000));
        step();
        chk("mid_rst_gid", DW'(o_grant_id), '0);
        run(10);

        // Randomized traffic against the model
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++)
                if (pq[k].size() == 0 && $urandom_range(0, 3) == 0)
                    push(k, int'($urandom_range(1, 20)), $urandom_range(0, 9) != 0,
                         {$urandom, $urandom, $urandom, $urandom});
            gap           = N'($urandom & $urandom);
            fifo_full     = ($urandom_range(0, 4) == 0);
            fifo_alm_full = ($urandom_range(0, 3) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single 128-bit write port of the width-converting FIFO (128-bit write, 8-bit read) between NUM_REQ producers. Each producer offers bursts over a valid/ready/last handshake. The arbiter locks the FIFO write port to one producer for a whole burst and honours the FIFO full and almost-full flags. It sits directly on the FIFO write side; the FIFO read side is untouched.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 128, write data width; equals FIFO write width
- MAX_BURST, 16, maximum beats per burst before forced termination (2..256)
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester beat valid
- req_last  input  NUM_REQ  per-requester last-beat marker, qualified by req_valid
- req_data  input  NUM_REQ*DATA_W  per-requester data; requester k occupies bits [k*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  per-requester beat accepted this cycle when valid&ready
- fifo_full  input  1  FIFO o_full
- fifo_alm_full  input  1  FIFO o_alm_full
- o_wren  output  1  FIFO i_wren
- o_wdata  output  DATA_W  FIFO i_wdata
- o_grant_id  output  clog2(NUM_REQ)  currently/last granted requester
- o_busy  output  1  burst in progress
- o_beat_cnt  output  clog2(MAX_BURST+1)  beats accepted in current burst
- o_total_cnt  output  32  total beats written since reset, wraps at 2^32
- o_err  output  1  sticky: a burst hit MAX_BURST without req_last

## Operation
- FSM with two states, IDLE and BURST. Reset state is IDLE.
- IDLE:
  - Arbitration runs when any req_valid=1 and fifo_alm_full=0.
  - Winner is the first requester with req_valid set, searching upward from (last_grant+1) mod NUM_REQ and wrapping.
  - Winner is registered into o_grant_id; FSM moves to BURST. o_beat_cnt clears to 0.
  - If fifo_alm_full=1, no new burst starts and the FSM stays in IDLE.
- BURST, with g=o_grant_id:
  - req_ready[g] = !fifo_full. All other req_ready are 0.
  - o_wren = req_valid[g] & !fifo_full.
  - o_wdata = req_data slice g (combinational mux).
  - fifo_alm_full does not stall an active burst; only fifo_full stalls it.
- On each accepted beat, o_beat_cnt and o_total_cnt increment by 1.
- Burst end:
  - Normal end: an accepted beat with req_last[g]=1. FSM goes to IDLE, last_grant<=g.
  - Forced end: the MAX_BURST-th beat is accepted without req_last. FSM goes to IDLE, last_grant<=g, o_err<=1.
  - o_err stays set until reset.
- last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.
- Requests from non-granted requesters are held off (ready=0) and never dropped.
- A requester may deassert valid mid-burst. The grant is held and no write occurs while valid is low.

## Timing
- Reset values:
  - FSM IDLE.
  - req_ready=0, o_wren=0, o_wdata=0.
  - o_grant_id=0, o_busy=0, o_beat_cnt=0, o_total_cnt=0, o_err=0.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge t can have its first beat accepted at edge t+1.
- Back-to-back bursts have exactly one IDLE bubble cycle between the last beat of one burst and the first beat of the next.
- o_wren and o_wdata are combinational from registered state and current inputs. The FIFO samples them at the same edge the beat is accepted (zero added latency in BURST).
- o_busy=1 exactly while the FSM is in BURST.
- Reset asserted mid-burst takes effect at the next edge:
  - FSM returns to IDLE, all counters and o_err clear, last_grant returns to NUM_REQ-1.
  - No write is issued in the reset cycle.
- Simultaneous fifo_full=1 and req_last on the granted requester: the beat is not accepted and the burst stays open.

## Test plan
- Single burst: after reset, requester 2 sends 3 beats (0xA..A1, A2, A3; last on the 3rd) with FIFO empty -> grant_id=2 one cycle after valid; 3 consecutive o_wren pulses carrying that data; o_total_cnt=3; o_busy returns to 0.
- Round-robin: all 4 requesters continuously send 1-beat bursts -> grant order 0,1,2,3,0,... with one bubble cycle between grants; each requester gets exactly 2 beats in 16 cycles.
- Backpressure: fifo_full forced to 1 for 5 cycles mid-burst on beat 2 of 4 -> o_wren=0 and req_ready=0 during the stall; beats 2..4 then written in order; no data duplicated or lost.
- Almost-full gating: fifo_alm_full=1 while requesters 1 and 3 are valid in IDLE -> no grant and o_busy=0 until alm_full drops. An already-active burst continues through alm_full=1.
- Forced end: MAX_BURST=16, requester 0 streams 20 beats with no last -> exactly 16 writes, then o_err=1, then grant passes to the next valid requester; o_err remains 1.
- Reset mid-burst: reset asserted on beat 2 of 5 -> next cycle all outputs at reset values; the first arbitration afterwards favours requester 0.
